// File: rtl/decoder_frame_ctrl_if.sv
// Handshake bundle between the frame controller and the deinterleaver, pairing stage and Viterbi decoder.
// The controller is the slave side; the surrounding datapath (or a bench) is the master side.
interface decoder_frame_ctrl_if;
  logic       enable;
  logic       frame_ready;
  logic       deint_start;
  logic       deint_out_valid;
  logic       pair_valid;
  logic       tail_valid;
  logic       tb_start;
  logic       tb_done;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic [2:0] err;

  modport master (
    output enable, frame_ready, deint_out_valid, pair_valid, tb_done,
    input  deint_start, tail_valid, tb_start, busy, frame_done, frame_cnt, err
  );

  modport slave (
    input  enable, frame_ready, deint_out_valid, pair_valid, tb_done,
    output deint_start, tail_valid, tb_start, busy, frame_done, frame_cnt, err
  );
endinterface

// File: rtl/decoder_frame_ctrl.sv
// Frame sequencer: deinterleaver readout, pair drain, zero-tail flush, traceback wait; outputs registered, 1 cycle after the decision.
// No backpressure: slow upstream stages simply lengthen STREAM/DRAIN, and a stalled traceback is cut off by the timeout.
module decoder_frame_ctrl #(
  parameter int FRAME_BITS = 64,
  parameter int TAIL_PAIRS = 6,
  parameter int PAIR_GAP   = 3,
  parameter int TB_TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset_n,
  decoder_frame_ctrl_if.slave fc
);
  localparam int PAIRS = FRAME_BITS / 2;
  localparam int BW    = $clog2(FRAME_BITS) + 1;
  localparam int PW    = $clog2(PAIRS) + 1;
  localparam int TW    = $clog2(TAIL_PAIRS) + 1;
  localparam int GW    = $clog2(PAIR_GAP) + 1;
  localparam int WW    = $clog2(TB_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, TAIL, TRACE, DONE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [2:0]    err_q, err_d;
  logic          pv_q, fr_q;
  logic          deint_start_q, tail_valid_q, tb_start_q, busy_q, frame_done_q;
  logic          deint_start_d, tail_valid_d, tb_start_d, busy_d, frame_done_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    gap_d       = gap_q;
    wait_d      = wait_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    // A pair is one 0->1 edge of pair_valid, however long the level is held.
    if ((state_q == STREAM || state_q == DRAIN) && fc.pair_valid && !pv_q && pair_cnt_q != '1)
      pair_cnt_d = pair_cnt_q + PW'(1);
    if (busy_q && fc.frame_ready && !fr_q)
      err_d[0] = 1'b1;
    if (fc.deint_out_valid && state_q != STREAM)
      err_d[1] = 1'b1;

    case (state_q)
      IDLE: begin
        if (fc.enable && fc.frame_ready)
          state_d = START;
      end
      START: begin
        bit_cnt_d  = '0;
        pair_cnt_d = '0;
        state_d    = STREAM;
      end
      STREAM: begin
        if (fc.deint_out_valid) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(FRAME_BITS - 1))
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pair_cnt_q >= PW'(PAIRS) && !fc.pair_valid) begin
          state_d    = TAIL;
          tail_cnt_d = '0;
          gap_d      = '0;
        end
      end
      TAIL: begin
        if (gap_q == '0 && tail_cnt_q < TW'(TAIL_PAIRS))
          tail_cnt_d = tail_cnt_q + TW'(1);
        gap_d = (gap_q == GW'(PAIR_GAP - 1)) ? '0 : gap_q + GW'(1);
        // Leave one full gap after the last strobe before starting traceback.
        if (gap_q == GW'(PAIR_GAP - 1) && tail_cnt_d == TW'(TAIL_PAIRS)) begin
          state_d = TRACE;
          wait_d  = '0;
        end
      end
      TRACE: begin
        wait_d = wait_q + WW'(1);
        if (wait_q != '0 && fc.tb_done) begin
          state_d     = DONE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (wait_d == WW'(TB_TIMEOUT)) begin
          state_d     = DONE;
          frame_cnt_d = frame_cnt_q + 8'd1;
          err_d[2]    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    deint_start_d = (state_d == START);
    busy_d        = (state_d != IDLE);
    tail_valid_d  = (state_d == TAIL) && (gap_d == '0) && (tail_cnt_d < TW'(TAIL_PAIRS));
    tb_start_d    = (state_d == TRACE) && (state_q != TRACE);
    frame_done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      pair_cnt_q    <= '0;
      tail_cnt_q    <= '0;
      gap_q         <= '0;
      wait_q        <= '0;
      frame_cnt_q   <= '0;
      err_q         <= '0;
      pv_q          <= 1'b0;
      fr_q          <= 1'b0;
      deint_start_q <= 1'b0;
      tail_valid_q  <= 1'b0;
      tb_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      pair_cnt_q    <= pair_cnt_d;
      tail_cnt_q    <= tail_cnt_d;
      gap_q         <= gap_d;
      wait_q        <= wait_d;
      frame_cnt_q   <= frame_cnt_d;
      err_q         <= err_d;
      pv_q          <= fc.pair_valid;
      fr_q          <= fc.frame_ready;
      deint_start_q <= deint_start_d;
      tail_valid_q  <= tail_valid_d;
      tb_start_q    <= tb_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign fc.deint_start = deint_start_q;
  assign fc.tail_valid  = tail_valid_q;
  assign fc.tb_start    = tb_start_q;
  assign fc.busy        = busy_q;
  assign fc.frame_done  = frame_done_q;
  assign fc.frame_cnt   = frame_cnt_q;
  assign fc.err         = err_q;
endmodule

// File: tb/tb_decoder_frame_ctrl.sv
// Directed bench for decoder_frame_ctrl: nominal, held pairs, timeout, error flags, mid-frame reset, counter wrap.
module tb_decoder_frame_ctrl;
  localparam int FRAME_BITS = 64;
  localparam int TAIL_PAIRS = 6;
  localparam int PAIR_GAP   = 3;
  localparam int TB_TIMEOUT = 255;
  localparam int PAIRS      = FRAME_BITS / 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n;
  int   s_fd;

  int mon_deint  = 0;
  int mon_tail   = 0;
  int mon_tbs    = 0;
  int mon_fd     = 0;
  int first_tail = 0;
  int last_tail  = 0;

  decoder_frame_ctrl_if fc();

  decoder_frame_ctrl #(
    .FRAME_BITS(FRAME_BITS),
    .TAIL_PAIRS(TAIL_PAIRS),
    .PAIR_GAP  (PAIR_GAP),
    .TB_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .fc     (fc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fc.deint_start === 1'b1) mon_deint++;
    if (fc.tb_start === 1'b1) mon_tbs++;
    if (fc.frame_done === 1'b1) mon_fd++;
    if (fc.tail_valid === 1'b1) begin
      mon_tail++;
      if (mon_tail % TAIL_PAIRS == 1) first_tail = cyc;
      last_tail = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // tb_delay < 0 means tb_done is never returned; glitch adds a frame_ready rise mid-stream
  // and a tb_done on the tb_start cycle.
  task automatic run_frame(input int tb_delay, input bit drop_ready, input bit glitch);
    int k, t0, tf, s_deint, s_tail, s_tbs, s_fdl;
    s_deint = mon_deint; s_tail = mon_tail; s_tbs = mon_tbs; s_fdl = mon_fd;
    k = 0;
    while (fc.deint_start !== 1'b1 && k < 50) begin tick(); k++; end
    check("deint_start_seen", fc.deint_start, 1);
    if (drop_ready) fc.frame_ready = 1'b0;
    tick();
    check("deint_start_one_cycle", fc.deint_start, 0);
    for (int i = 0; i < 4 * PAIRS; i++) begin
      fc.deint_out_valid = (i < FRAME_BITS);
      fc.pair_valid      = (i % 4) != 3;
      if (glitch && i == 10) fc.frame_ready = 1'b1;
      if (glitch && i == 12) fc.frame_ready = 1'b0;
      tick();
      if (i == 4 * PAIRS - 2) begin
        check("pair_cnt_held", dut.pair_cnt_q, PAIRS);
        check("drain_waits_for_fall", fc.tail_valid, 0);
      end
    end
    fc.deint_out_valid = 1'b0;
    fc.pair_valid      = 1'b0;
    check("tail_first_strobe", fc.tail_valid, 1);
    k = 0;
    while (fc.tb_start !== 1'b1 && k < 100) begin tick(); k++; end
    check("tb_start_seen", fc.tb_start, 1);
    t0 = cyc;
    check("tail_count", mon_tail - s_tail, TAIL_PAIRS);
    check("tail_span", last_tail - first_tail, (TAIL_PAIRS - 1) * PAIR_GAP);
    check("tail_to_trace", t0 - last_tail, PAIR_GAP);
    if (glitch) begin
      fc.tb_done = 1'b1;
      tick();
      fc.tb_done = 1'b0;
      check("tb_done_ignored_on_start", fc.frame_done, 0);
      check("still_busy_after_ignored", fc.busy, 1);
    end
    if (tb_delay >= 0) begin
      while (cyc < t0 + tb_delay) tick();
      fc.tb_done = 1'b1;
      tick();
      fc.tb_done = 1'b0;
    end
    k = 0;
    while (fc.frame_done !== 1'b1 && k < TB_TIMEOUT + 20) begin tick(); k++; end
    check("frame_done_seen", fc.frame_done, 1);
    tf = cyc;
    check("trace_latency", tf - t0, (tb_delay >= 0) ? tb_delay + 1 : TB_TIMEOUT);
    check("busy_in_done", fc.busy, 1);
    tick();
    check("frame_done_one_cycle", fc.frame_done, 0);
    check("deint_start_count", mon_deint - s_deint, 1);
    check("tb_start_count", mon_tbs - s_tbs, 1);
    check("frame_done_count", mon_fd - s_fdl, 1);
  endtask

  initial begin
    fc.enable = 1'b0; fc.frame_ready = 1'b0; fc.deint_out_valid = 1'b0;
    fc.pair_valid = 1'b0; fc.tb_done = 1'b0;
    #2 reset_n = 1'b0;
    fc.enable = 1'b1; fc.frame_ready = 1'b1; fc.deint_out_valid = 1'b1;
    repeat (3) tick();
    check("rst_busy", fc.busy, 0);
    check("rst_deint_start", fc.deint_start, 0);
    check("rst_tail_valid", fc.tail_valid, 0);
    check("rst_tb_start", fc.tb_start, 0);
    check("rst_frame_done", fc.frame_done, 0);
    check("rst_frame_cnt", fc.frame_cnt, 0);
    check("rst_err", fc.err, 0);
    fc.enable = 1'b0; fc.frame_ready = 1'b0; fc.deint_out_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Nominal frame with held pairs
    fc.enable = 1'b1; fc.frame_ready = 1'b1;
    run_frame(10, 1'b1, 1'b0);
    check("nom_frame_cnt", fc.frame_cnt, 1);
    check("nom_err", fc.err, 0);
    check("nom_idle", fc.busy, 0);

    // Traceback timeout
    fc.frame_ready = 1'b1;
    run_frame(-1, 1'b1, 1'b0);
    check("to_frame_cnt", fc.frame_cnt, 2);
    check("to_err", fc.err, 3'b100);

    // enable=0 blocks the start, then a normal frame after the timeout
    fc.enable = 1'b0; fc.frame_ready = 1'b1;
    repeat (5) tick();
    check("enable_blocks_start", fc.busy, 0);
    fc.enable = 1'b1;
    run_frame(10, 1'b1, 1'b0);
    check("after_to_frame_cnt", fc.frame_cnt, 3);
    check("after_to_err", fc.err, 3'b100);

    // Spurious coded bit while idle
    fc.deint_out_valid = 1'b1;
    tick();
    fc.deint_out_valid = 1'b0;
    tick();
    check("spurious_err", fc.err, 3'b110);
    check("spurious_bit_cnt", dut.bit_cnt_q, FRAME_BITS);
    check("spurious_idle", fc.busy, 0);

    // frame_ready rising mid-stream, tb_done on the tb_start cycle
    fc.frame_ready = 1'b1;
    run_frame(10, 1'b1, 1'b1);
    check("overrun_err", fc.err, 3'b111);
    check("overrun_frame_cnt", fc.frame_cnt, 4);

    // Asynchronous reset at bit 20
    fc.frame_ready = 1'b1;
    n = 0;
    while (fc.deint_start !== 1'b1 && n < 50) begin tick(); n++; end
    check("mid_deint_start_seen", fc.deint_start, 1);
    fc.frame_ready = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      fc.deint_out_valid = 1'b1;
      fc.pair_valid      = (i % 4) != 3;
      tick();
    end
    check("mid_bit_cnt", dut.bit_cnt_q, 20);
    check("mid_pair_cnt", dut.pair_cnt_q, 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", fc.busy, 0);
    check("mid_rst_frame_cnt", fc.frame_cnt, 0);
    check("mid_rst_err", fc.err, 0);
    check("mid_rst_bit_cnt", dut.bit_cnt_q, 0);
    check("mid_rst_pair_cnt", dut.pair_cnt_q, 0);
    fc.deint_out_valid = 1'b0; fc.pair_valid = 1'b0;
    tick(); tick();
    check("mid_rst_strobes", {fc.deint_start, fc.tail_valid, fc.tb_start, fc.frame_done}, 0);
    reset_n = 1'b1;
    tick();
    fc.frame_ready = 1'b1;
    run_frame(10, 1'b1, 1'b0);
    check("post_rst_frame_cnt", fc.frame_cnt, 1);
    check("post_rst_err", fc.err, 0);

    // 256 back-to-back frames wrap the counter
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    s_fd = mon_fd;
    fc.enable = 1'b1; fc.frame_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      run_frame(1, 1'b0, 1'b0);
      check("wrap_frame_cnt", fc.frame_cnt, (k + 1) % 256);
    end
    check("wrap_done_total", mon_fd - s_fd, 256);
    check("wrap_final_cnt", fc.frame_cnt, 0);
    check("wrap_err", fc.err, 0);
    fc.enable = 1'b0; fc.frame_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/decoder_frame_ctrl.md
DECODER_FRAME_CTRL -- requirements
Module: decoder_frame_ctrl

Interface
REQ-001 Parameter FRAME_BITS, default 64, coded bits per frame read from the deinterleaver; SHALL be even and at least 4.
REQ-002 Parameter TAIL_PAIRS, default 6, number of zero tail pairs injected into the Viterbi decoder for trellis flush.
REQ-003 Parameter PAIR_GAP, default 3, cycles between consecutive tail-pair strobes.
REQ-004 Parameter TB_TIMEOUT, default 255, maximum cycles to wait for traceback completion.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous and active-low.
REQ-007 enable  in  1  permits the start of a new frame.
REQ-008 frame_ready  in  1  level; deinterleaver holds a complete frame.
REQ-009 deint_start  out  1  one-cycle pulse that starts deinterleaver readout.
REQ-010 deint_out_valid  in  1  one coded bit presented to the pairing stage this cycle.
REQ-011 pair_valid  in  1  Viterbi input-valid as driven by the pairing stage; may be held several cycles per pair.
REQ-012 tail_valid  out  1  one-cycle strobe injecting one zero tail pair.
REQ-013 tb_start  out  1  one-cycle pulse that starts Viterbi traceback.
REQ-014 tb_done  in  1  traceback-complete pulse.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 frame_done  out  1  one-cycle pulse at end of frame.
REQ-017 frame_cnt  out  8  completed-frame counter.
REQ-018 err  out  3  sticky flags: [0] overrun, [1] spurious bit, [2] traceback timeout.

Function
REQ-019 FSM states SHALL be IDLE, START, STREAM, DRAIN, TAIL, TRACE and DONE; all outputs SHALL be registered.
REQ-020 IDLE->START when enable=1 and frame_ready=1; START SHALL last exactly one cycle with deint_start=1, then go to STREAM.
REQ-021 STREAM SHALL count deint_out_valid cycles in bit_cnt, which is cleared on START.
REQ-022 A valid with bit_cnt=FRAME_BITS-1 SHALL go to DRAIN.
REQ-023 A pair SHALL be counted on each rising edge of pair_valid, 0->1 relative to the previous cycle; a held level SHALL count once.
REQ-024 Pairs SHALL be counted in STREAM and DRAIN.
REQ-025 DRAIN SHALL exit to TAIL once pair_cnt=FRAME_BITS/2 and pair_valid=0.
REQ-026 TAIL SHALL issue exactly TAIL_PAIRS tail_valid strobes.
REQ-027 The first tail_valid strobe SHALL occur on the first TAIL cycle; later strobes SHALL be PAIR_GAP cycles apart.
REQ-028 TAIL SHALL go to TRACE PAIR_GAP cycles after the last strobe.
REQ-029 On entering TRACE, tb_start SHALL pulse for one cycle, and a wait counter SHALL start.
REQ-030 TRACE SHALL exit when tb_done=1, or when the wait counter reaches TB_TIMEOUT; the timeout SHALL set err[2].
REQ-031 tb_done SHALL be ignored on the tb_start cycle.
REQ-032 DONE SHALL last one cycle with frame_done=1 and frame_cnt incremented, wrapping 255->0, then go to IDLE.
REQ-033 A frame that ends by timeout SHALL still pass through DONE.
REQ-034 frame_ready=1 on the cycle busy rises SHALL be accepted; frame_ready rising from 0 to 1 while busy=1 SHALL set err[0].
REQ-035 deint_out_valid=1 in any state other than STREAM SHALL set err[1] and SHALL NOT alter bit_cnt.
REQ-036 enable=0 SHALL only block IDLE->START; a frame in progress SHALL complete.
REQ-037 Counter widths SHALL be $clog2 of their terminal values plus 1; no counter SHALL wrap inside a frame.

Reset
REQ-038 reset_n=0 SHALL immediately force IDLE, including mid-frame.
REQ-039 While reset_n=0, deint_start, tail_valid, tb_start, frame_done and busy SHALL be 0, frame_cnt=0, err=000, and all internal counters 0.
REQ-040 err flags SHALL clear only by reset.

Verification
REQ-041 Nominal: FRAME_BITS=64, enable=1, frame_ready=1, 64 valids, 32 pair_valid pulses each 3 cycles wide, tb_done 10 cycles after tb_start -> 1 deint_start, 6 tail_valid strobes 3 cycles apart, 1 tb_start, frame_done once, frame_cnt=1, err=000.
REQ-042 Held pair_valid: 32 pairs, each held 3 cycles -> pair_cnt=32 (not 96), and DRAIN exits only after pair_valid falls.
REQ-043 Timeout: tb_done never asserted -> frame_done TB_TIMEOUT cycles after tb_start, err=100, and the next frame runs normally.
REQ-044 Errors: deint_out_valid pulsed in IDLE -> err[1]=1 with bit_cnt unchanged; frame_ready rising during STREAM -> err[0]=1.
REQ-045 Reset mid-STREAM at bit 20 -> all outputs 0 and IDLE; the following full frame completes with frame_cnt=1.
REQ-046 Wrap: 256 back-to-back frames -> frame_cnt=0, with frame_done issued 256 times.
